// File: rtl/vec_cache.sv
// ============================================================================
//  Module   : vec_cache (with package vec_pkg)
//  Purpose  : WIDTH x WIDTH x 32-bit vector register cache, combinational read.
//  Options  : define VEC_CACHE_FWD_EN for same-cycle write-to-read forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_pkg;
   typedef enum logic [0:0] {
      VEC_DATA_READ_DISABLE = 1'b0,
      VEC_DATA_READ_VEC     = 1'b1
   } VecDataReadOp_t;

   typedef enum logic [1:0] {
      VEC_DATA_WRITE_DISABLE = 2'd0,
      VEC_DATA_WRITE_VEC     = 2'd1,
      VEC_DATA_WRITE_SCALAR  = 2'd2
   } VecDataWriteOp_t;
endpackage

module vec_cache
   import vec_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int AW    = $clog2(WIDTH)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  VecDataReadOp_t              read_op,
   input  logic [AW-1:0]               read_addr,
   input  VecDataWriteOp_t             write_op,
   input  logic [AW-1:0]               write_addr,
   input  logic [AW-1:0]               write_param,
   input  logic [WIDTH-1:0][31:0]      data_in,
   output logic [WIDTH-1:0][31:0]      data_out
);

   logic [WIDTH-1:0][WIDTH-1:0][31:0] r_mem;
   logic [WIDTH-1:0][31:0]            w_row;

   // Reset takes priority over any write presented on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem <= '0;
      end else begin
         case (write_op)
            VEC_DATA_WRITE_VEC:    r_mem[write_addr]              <= data_in;
            VEC_DATA_WRITE_SCALAR: r_mem[write_addr][write_param] <= data_in[0];
            default:               ;
         endcase
      end
   end

   always_comb begin
      w_row = r_mem[read_addr];
`ifdef VEC_CACHE_FWD_EN
      if (write_addr == read_addr) begin
         if (write_op == VEC_DATA_WRITE_VEC) begin
            w_row = data_in;
         end else if (write_op == VEC_DATA_WRITE_SCALAR) begin
            w_row[write_param] = data_in[0];
         end
      end
`endif
      data_out = (read_op == VEC_DATA_READ_VEC) ? w_row : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_vec_cache.sv
// ============================================================================
//  Module   : tb_vec_cache
//  Purpose  : Directed self-checking bench for vec_cache at WIDTH=4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_cache;
   import vec_pkg::*;

   localparam int WIDTH = 4;
   localparam int AW    = 2;

   typedef logic [WIDTH-1:0][31:0] vec_t;

   logic            clock;
   logic            reset;
   VecDataReadOp_t  read_op;
   logic [AW-1:0]   read_addr;
   VecDataWriteOp_t write_op;
   logic [AW-1:0]   write_addr;
   logic [AW-1:0]   write_param;
   vec_t            data_in;
   vec_t            data_out;

   int pass_cnt = 0;
   int total    = 0;

   vec_cache #(.WIDTH(WIDTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .read_op     (read_op),
      .read_addr   (read_addr),
      .write_op    (write_op),
      .write_addr  (write_addr),
      .write_param (write_param),
      .data_in     (data_in),
      .data_out    (data_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // IEEE-754 single-precision encodings of small integers.
   function automatic logic [31:0] fp(input int n);
      case (n)
         0:       fp = 32'h0000_0000;
         1:       fp = 32'h3F80_0000;
         2:       fp = 32'h4000_0000;
         3:       fp = 32'h4040_0000;
         4:       fp = 32'h4080_0000;
         5:       fp = 32'h40A0_0000;
         6:       fp = 32'h40C0_0000;
         7:       fp = 32'h40E0_0000;
         9:       fp = 32'h4110_0000;
         default: fp = 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic vec_t v4(input int a, input int b, input int c, input int d);
      vec_t r;
      r[0] = fp(a);
      r[1] = fp(b);
      r[2] = fp(c);
      r[3] = fp(d);
      return r;
   endfunction

   task automatic check(input string tag, input vec_t obs, input vec_t exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      read_op   = VEC_DATA_READ_VEC;
      read_addr = a;
      #1;
   endtask

   task automatic wr_vec(input logic [AW-1:0] a, input vec_t d);
      write_op   = VEC_DATA_WRITE_VEC;
      write_addr = a;
      data_in    = d;
      tick();
      write_op   = VEC_DATA_WRITE_DISABLE;
   endtask

   initial begin
      reset       = 1'b1;
      read_op     = VEC_DATA_READ_DISABLE;
      read_addr   = '0;
      write_op    = VEC_DATA_WRITE_DISABLE;
      write_addr  = '0;
      write_param = '0;
      data_in     = '0;
      tick();
      tick();
      reset = 1'b0;

      rd(2'd0); check("reset_row0", data_out, '0);
      rd(2'd3); check("reset_row3", data_out, '0);

      wr_vec(2'd0, v4(4, 6, 1, 6));
      wr_vec(2'd1, v4(9, 7, 5, 3));
      wr_vec(2'd2, v4(5, 3, 0, 3));
      wr_vec(2'd3, v4(5, 3, 0, 3));
      rd(2'd1); check("read_row1", data_out, v4(9, 7, 5, 3));
      rd(2'd0); check("read_row0", data_out, v4(4, 6, 1, 6));
      rd(2'd3); check("read_row3", data_out, v4(5, 3, 0, 3));

      write_op = VEC_DATA_WRITE_DISABLE; write_addr = 2'd1; data_in = v4(7, 3, 2, 1);
      tick();
      rd(2'd1); check("wr_disable", data_out, v4(9, 7, 5, 3));

      write_op = VecDataWriteOp_t'(2'd3); write_addr = 2'd1; data_in = v4(7, 3, 2, 1);
      tick();
      write_op = VEC_DATA_WRITE_DISABLE;
      rd(2'd1); check("wr_unlisted", data_out, v4(9, 7, 5, 3));

      write_op = VEC_DATA_WRITE_SCALAR; write_addr = 2'd1; write_param = 2'd2;
      data_in = v4(2, 7, 7, 7);
      tick();
      write_op = VEC_DATA_WRITE_DISABLE;
      rd(2'd1); check("scalar_row1", data_out, v4(9, 7, 2, 3));
      rd(2'd2); check("scalar_other_row", data_out, v4(5, 3, 0, 3));

      read_op = VEC_DATA_READ_DISABLE; read_addr = 2'd1; #1;
      check("read_disable", data_out, '0);

      // Same-cycle vector write and read of row 2.
      write_op = VEC_DATA_WRITE_VEC; write_addr = 2'd2; data_in = v4(1, 2, 3, 4);
      rd(2'd2);
`ifdef VEC_CACHE_FWD_EN
      check("same_row_pre_edge", data_out, v4(1, 2, 3, 4));
`else
      check("same_row_pre_edge", data_out, v4(5, 3, 0, 3));
`endif
      rd(2'd1); check("diff_row_independent", data_out, v4(9, 7, 2, 3));
      tick();
      write_op = VEC_DATA_WRITE_DISABLE;
      rd(2'd2); check("same_row_post_edge", data_out, v4(1, 2, 3, 4));

      // Same-cycle scalar write and read of row 3.
      write_op = VEC_DATA_WRITE_SCALAR; write_addr = 2'd3; write_param = 2'd0;
      data_in = v4(9, 1, 1, 1);
      rd(2'd3);
`ifdef VEC_CACHE_FWD_EN
      check("scalar_same_row_pre", data_out, v4(9, 3, 0, 3));
`else
      check("scalar_same_row_pre", data_out, v4(5, 3, 0, 3));
`endif
      tick();
      write_op = VEC_DATA_WRITE_DISABLE;
      rd(2'd3); check("scalar_same_row_post", data_out, v4(9, 3, 0, 3));

      // Reset overrides a same-cycle write and discards everything.
      reset = 1'b1;
      write_op = VEC_DATA_WRITE_VEC; write_addr = 2'd0; data_in = v4(7, 7, 7, 7);
      tick();
      reset = 1'b0;
      write_op = VEC_DATA_WRITE_DISABLE;
      rd(2'd0); check("reset_beats_write", data_out, '0);
      rd(2'd1); check("reset_clears_row1", data_out, '0);

      wr_vec(2'd0, v4(1, 2, 3, 4));
      rd(2'd0); check("write_after_reset", data_out, v4(1, 2, 3, 4));

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

`default_nettype wire
